axis_vip_master: RTL and testbench

AXIS_VIP_MASTER -- requirements
Module: axis_vip_master

---
 rtl/axis_vip_pkg.sv | 19 +
 rtl/axis_vip_frame_gen.sv | 93 +++++++++
 rtl/axis_vip_master.sv | 74 +++++++
 tb/tb_axis_vip_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_vip_pkg.sv
// rtl/axis_vip_pkg.sv - shared types, constants and helpers for the AXI-Stream master VIP
package axis_vip_pkg;

  // Generator state: wait for first enabled cycle, stream beats, finished
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the free-running beat, beat-in-frame and frame counters
  localparam int BEAT_CNT_W = 32;

  // Port width for optional fields: a zero-width field still gets one bit
  function automatic int max1(input int w);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/axis_vip_frame_gen.sv
// rtl/axis_vip_frame_gen.sv - beat/frame counters and IDLE/SEND/DONE sequencing (optional AXIS_VIP_MASTER_IDLE_GAP_EN)
module axis_vip_frame_gen
  import axis_vip_pkg::*;
#(
  parameter int FRAME_LEN  = 16,
  parameter int NUM_FRAMES = 2
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ready,
  output logic                  valid,
  output logic                  last,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic [BEAT_CNT_W-1:0] beat_idx,
  output logic [BEAT_CNT_W-1:0] frame_idx
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT   = BEAT_CNT_W'(FRAME_LEN - 1);
  localparam logic [BEAT_CNT_W-1:0] FINAL_FRAME = BEAT_CNT_W'(NUM_FRAMES - 1);

  state_t state;
  state_t state_nxt;
  logic   xfer;
  logic   at_last_beat;
  logic   frame_end;
  logic   run_end;

  // A beat moves only on an enabled edge while we are presenting one
  assign xfer         = en && (state == SEND) && ready;
  assign at_last_beat = (beat_idx == LAST_BEAT);
  assign frame_end    = xfer && at_last_beat;
  assign run_end      = frame_end && (NUM_FRAMES != 0) && (frame_idx == FINAL_FRAME);

  // State register; a disabled clock leaves the state untouched
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // Next state and beat qualifiers; the optional inter-frame gap reuses IDLE for one cycle
  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        last  = at_last_beat;
        if (run_end) begin
          state_nxt = DONE;
        end
`ifdef AXIS_VIP_MASTER_IDLE_GAP_EN
        else if (frame_end) begin
          state_nxt = IDLE;
        end
`endif
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters advance once per accepted beat; frame index steps on the last beat
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      beat_idx  <= '0;
      frame_idx <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      if (at_last_beat) begin
        beat_idx  <= '0;
        frame_idx <= frame_idx + BEAT_CNT_W'(1);
      end else begin
        beat_idx <= beat_idx + BEAT_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/axis_vip_master.sv
// rtl/axis_vip_master.sv - AXI-Stream master VIP top: parameter/port adaptation around the frame generator (optional AXIS_VIP_MASTER_IDLE_GAP_EN)
module axis_vip_master
  import axis_vip_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 0,
  parameter int TID_WIDTH   = 0,
  parameter int TDEST_WIDTH = 0,
  parameter int HAS_TREADY  = 1,
  parameter int HAS_TSTRB   = 0,
  parameter int HAS_TKEEP   = 0,
  parameter int HAS_TLAST   = 0,
  parameter int HAS_ARESETN = 1,
  parameter int HAS_ACLKEN  = 0,
  parameter int FRAME_LEN   = 16,
  parameter int NUM_FRAMES  = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          aclken,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic [max1(TDEST_WIDTH)-1:0]  m_axis_tdest,
  output logic [max1(TID_WIDTH)-1:0]    m_axis_tid,
  output logic [TDATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  output logic [TDATA_WIDTH/8-1:0]      m_axis_tstrb,
  output logic [max1(TUSER_WIDTH)-1:0]  m_axis_tuser,
  input  logic                          m_axis_tready
);

  localparam int TDEST_W = max1(TDEST_WIDTH);
  localparam int TUSER_W = max1(TUSER_WIDTH);

  logic                  rst_eff;
  logic                  en_eff;
  logic                  ready_eff;
  logic                  gen_valid;
  logic                  gen_last;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [BEAT_CNT_W-1:0] beat_idx;
  logic [BEAT_CNT_W-1:0] frame_idx;

  // Optional control inputs collapse to their inactive value when not honoured
  assign rst_eff   = (HAS_ARESETN != 0) ? areset : 1'b0;
  assign en_eff    = (HAS_ACLKEN != 0) ? aclken : 1'b1;
  assign ready_eff = (HAS_TREADY != 0) ? m_axis_tready : 1'b1;

  axis_vip_frame_gen #(
    .FRAME_LEN  (FRAME_LEN),
    .NUM_FRAMES (NUM_FRAMES)
  ) IF (
    .aclk      (aclk),
    .rst       (rst_eff),
    .en        (en_eff),
    .ready     (ready_eff),
    .valid     (gen_valid),
    .last      (gen_last),
    .beat_cnt  (beat_cnt),
    .beat_idx  (beat_idx),
    .frame_idx (frame_idx)
  );

  // Every output is a pure function of registered state, so stalls hold them stable
  assign m_axis_tvalid = gen_valid;
  assign m_axis_tdata  = TDATA_WIDTH'(beat_cnt);
  assign m_axis_tlast  = (HAS_TLAST != 0) ? gen_last : 1'b0;
  assign m_axis_tdest  = (TDEST_WIDTH > 0) ? TDEST_W'(frame_idx) : '0;
  assign m_axis_tuser  = (TUSER_WIDTH > 0) ? TUSER_W'(beat_idx) : '0;
  assign m_axis_tid    = '0;
  assign m_axis_tkeep  = '1;
  assign m_axis_tstrb  = '1;

endmodule

// File: tb/tb_axis_vip_master.sv
// tb/tb_axis_vip_master.sv - scoreboard bench for axis_vip_master (honours AXIS_VIP_MASTER_IDLE_GAP_EN)
`timescale 1ns/1ps
module tb_axis_vip_master;

  localparam int FL    = 4;
  localparam int NF    = 8;
  localparam int TOTAL = FL * NF;
`ifdef AXIS_VIP_MASTER_IDLE_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        aclken;
  logic        tready;
  logic [31:0] tdata;
  logic [1:0]  tdest;
  logic [0:0]  tid;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic [3:0]  tstrb;
  logic [1:0]  tuser;

  axis_vip_master #(
    .TDATA_WIDTH (32),
    .TUSER_WIDTH (2),
    .TID_WIDTH   (0),
    .TDEST_WIDTH (2),
    .HAS_TREADY  (1),
    .HAS_TSTRB   (1),
    .HAS_TKEEP   (1),
    .HAS_TLAST   (1),
    .HAS_ARESETN (1),
    .HAS_ACLKEN  (1),
    .FRAME_LEN   (FL),
    .NUM_FRAMES  (NF)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .aclken        (aclken),
    .m_axis_tdata  (tdata),
    .m_axis_tdest  (tdest),
    .m_axis_tid    (tid),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tstrb  (tstrb),
    .m_axis_tuser  (tuser),
    .m_axis_tready (tready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  dest;
    logic [1:0]  user;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec    = 0;
  int    n_err    = 0;
  int    xfer_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: beat k of the run carries k, frame k/FL, position k%FL
  task automatic load_expected();
    exp_q.delete();
    for (int k = 0; k < TOTAL; k++) begin
      beat_t b;
      b.data = 32'(k);
      b.last = ((k % FL) == FL - 1);
      b.dest = 2'((k / FL) % 4);
      b.user = 2'((k % FL) % 4);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: sample mid-cycle, predict the upcoming edge, compare against the scoreboard
  initial begin : monitor
    beat_t cur;
    beat_t prev;
    beat_t exp_b;
    logic  prev_valid;
    bit    hold_req;
    bit    gap_pending;
    hold_req    = 1'b0;
    gap_pending = 1'b0;
    prev        = '0;
    prev_valid  = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        hold_req    = 1'b0;
        gap_pending = 1'b0;
      end else begin
        cur = {tdata, tlast, tdest, tuser};
        if (hold_req) begin
          check("hold_stable", 64'({tvalid, cur}), 64'({prev_valid, prev}));
        end
        if (gap_pending) begin
          check("frame_boundary_tvalid", 64'(tvalid), 64'(!GAP));
          gap_pending = 1'b0;
        end
        if (tvalid && tready && aclken) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(1), 64'(0));
          end else begin
            exp_b = exp_q.pop_front();
            check("beat", 64'(cur), 64'(exp_b));
            check("beat_tid_tkeep_tstrb", 64'({tid, tkeep, tstrb}), 64'({1'b0, 4'hf, 4'hf}));
            xfer_cnt++;
            if (exp_b.last && exp_q.size() > 0) gap_pending = 1'b1;
          end
        end else if (exp_q.size() == 0) begin
          check("done_tvalid_low", 64'(tvalid), 64'(0));
        end
        hold_req   = !aclken || (tvalid && !tready);
        prev       = cur;
        prev_valid = tvalid;
      end
    end
  end

  // mode 0: tready=1; mode 1: tready toggles; mode 2: random tready/aclken plus a 10-cycle freeze
  task automatic run(input int mode, input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      @(posedge aclk);
      #1;
      case (mode)
        0: begin tready = 1'b1; aclken = 1'b1; end
        1: begin tready = ~tready; aclken = 1'b1; end
        default: begin
          tready = 1'($urandom_range(0, 1));
          if (cyc >= 12 && cyc < 22) aclken = 1'b0;
          else aclken = ($urandom_range(0, 9) != 0);
        end
      endcase
      cyc++;
    end
    check({name, "_timeout"}, 64'(exp_q.size()), 64'(0));
    aclken = 1'b1;
    tready = 1'b1;
    repeat (12) @(posedge aclk);
    #1;
    check({name, "_done_tvalid"}, 64'(tvalid), 64'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    load_expected();
    #1 areset = 1'b0;
  endtask

  initial begin : stim
    int base;
    int cyc;
    areset = 1'b1;
    aclken = 1'b1;
    tready = 1'b0;
    #1;
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_tdest_tuser_tid", 64'({tdest, tuser, tid}), 64'(0));
    check("rst_tkeep_tstrb", 64'({tkeep, tstrb}), 64'(8'hff));

    do_reset();
    tready = 1'b1;
    run(0, "full_rate");

    do_reset();
    tready = 1'b0;
    run(1, "toggle_ready");

    do_reset();
    base = xfer_cnt;
    cyc  = 0;
    while (xfer_cnt - base < 6 && cyc < 500) begin
      @(posedge aclk);
      #1;
      tready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("pre_reset_beats", 64'(xfer_cnt - base), 64'(6));
    #1 areset = 1'b1;
    #1;
    check("async_rst_tvalid", 64'(tvalid), 64'(0));
    check("async_rst_tdata", 64'(tdata), 64'(0));
    check("async_rst_fields", 64'({tlast, tdest, tuser}), 64'(0));
    do_reset();
    run(2, "random_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
